sar_adc_sampler: RTL and testbench
==================================

# sar_adc_sampler

Behavioural successive-approximation ADC that sits directly downstream of the channel models: it samples the channel's real-valued output `y` on a start request and resolves it into an NBITS binary code over NBITS clock cycles. The code and a one-cycle valid strobe are delivered to the data-capture / ML dataset logic. The block is simulation-only real-number RTL and is not synthesizable.

## Interface
- `NBITS`, 6: resolution in bits; legal range 2..12.
- `VREF_P`, 0.5 (real): top of input range.
- `VREF_N`, -0.5 (real): bottom of input range; must satisfy `VREF_N < VREF_P`.

- `clk`, in, 1: conversion clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `vin`, in, real: analog input; connects to the channel output `y`.
- `start`, in, 1: conversion request; sampled only on a rising edge while idle.
- `busy`, out, 1: high while a conversion is in progress.
- `dout`, out, NBITS: last completed code, in unsigned offset-binary.
- `valid`, out, 1: one-cycle strobe; `dout` is new in the same cycle.
- `ovr`, out, 1: present only with `SAR_ADC_OVR_EN`; marks that the last code was out of range.

## Operation
- LSB = (VREF_P - VREF_N) / 2^NBITS, computed in real arithmetic.
- Threshold for trial code t = VREF_N + t*LSB.
- States:
  - IDLE: `busy`=0. On an edge with `start`=1: latch `vin` into the real register `vhold`, clear the trial register, set bit index i=NBITS-1, go to CONV.
  - CONV: each edge, set bit i of the trial. If `vhold >= threshold(trial)`, keep the bit; otherwise clear it. Decrement i.
  - When i=0 is decided: load `dout` with the final code, pulse `valid`, go to IDLE.
- Only one IDLE→CONV transition and one CONV→IDLE transition exist; there is no separate DONE state.
- `vhold` is frozen for the whole conversion. Changes on `vin` after the sampling edge do not affect the result.
- Tie rule: `vhold` exactly equal to a threshold resolves that bit to 1.
- Out-of-range inputs saturate naturally:
  - `vin >= VREF_P` gives all ones.
  - `vin < VREF_N` gives 0.
- `start` while `busy`=1 is ignored. It is not queued.
- `dout` holds its value between conversions and changes only on the `valid` cycle.
- Reset (any time, including mid-conversion):
  - State→IDLE, `busy`=0, `valid`=0, `dout`=0, `vhold`=0.0, trial=0, `ovr`=0.
  - An aborted conversion never produces `valid`.

## Timing
- Sampling edge E0: the rising edge where IDLE sees `start`=1.
- `busy` goes high after E0.
- Bits MSB..LSB are decided on edges E1..E_NBITS.
- After E_NBITS: `valid`=1 for exactly one cycle, `dout` is updated, `busy`=0.
- Latency from E0 to `valid` is NBITS edges.
- The earliest next accepted start is E_NBITS+1, so throughput is one conversion per NBITS+1 cycles.
- With `start` held high continuously, sampling edges repeat every NBITS+1 cycles.
- All outputs are registered. There is no combinational path from `vin` or `start` to any output.

## Configuration
- `SAR_ADC_OVR_EN` defined:
  - Port `ovr` exists.
  - At the sampling edge, `ovr_pending` = (`vin >= VREF_P`) || (`vin < VREF_N`).
  - `ovr` is loaded from `ovr_pending` on the `valid` edge and held with `dout`.
- Not defined: port `ovr` and its logic are absent. Codes are identical in both builds.

## Test plan
All cases use NBITS=6, VREF ±0.5, LSB=0.015625.
- `vin`=0.0, one `start` pulse → `valid` 6 edges after the sampling edge, `dout`=32, `busy` high for exactly 6 cycles.
- `vin`=0.1 sampled, then `vin` driven to -0.4 on the next cycle → `dout`=38 (hold isolation).
- `vin`=-0.1875 (exact threshold 20) → `dout`=20. `vin`=0.49 → 63. `vin`=-0.5 → 0.
- With `SAR_ADC_OVR_EN`:
  - `vin`=0.6 → `dout`=63, `ovr`=1.
  - Then `vin`=0.0 → `dout`=32, `ovr`=0.
- `start` held high with a ramping `vin` → sampling edges spaced 7 cycles apart; extra `start` pulses during `busy` produce no extra `valid`.
- `rst` asserted at the 3rd CONV cycle → outputs immediately 0/IDLE, no `valid`. A `start` after release converts correctly (0.0 → 32).

Source files
------------

// File: rtl/sar_adc_sampler_if.sv
// Start/busy/result bundle between a sampling requester and sar_adc_sampler.
// The ovr line exists only when SAR_ADC_OVR_EN is defined.
interface sar_adc_sampler_if #(
  parameter int NBITS = 6
);
  real              vin;
  logic             start;
  logic             busy;
  logic [NBITS-1:0] dout;
  logic             valid;
`ifdef SAR_ADC_OVR_EN
  logic             ovr;
`endif

  modport master (
    output vin,
    output start,
    input  busy,
    input  dout,
`ifdef SAR_ADC_OVR_EN
    input  ovr,
`endif
    input  valid
  );

  modport slave (
    input  vin,
    input  start,
    output busy,
    output dout,
`ifdef SAR_ADC_OVR_EN
    output ovr,
`endif
    output valid
  );
endinterface

// File: rtl/sar_adc_sampler.sv
// Behavioural real-valued SAR ADC: samples vin on start and resolves one bit per clock, MSB first.
// Optional out-of-range flag (ovr) is built when SAR_ADC_OVR_EN is defined.
module sar_adc_sampler #(
  parameter int  NBITS  = 6,
  parameter real VREF_P = 0.5,
  parameter real VREF_N = -0.5
) (
  input  logic               clk,
  input  logic               rst,
  sar_adc_sampler_if.slave   bus
);
  localparam int  IW  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam real LSB = (VREF_P - VREF_N) / real'(2 ** NBITS);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_reg, state_next;
  real              vhold_reg, vhold_next;
  logic [NBITS-1:0] trial_reg, trial_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [NBITS-1:0] dout_reg, dout_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic [NBITS-1:0] trial_set;
  real              threshold;
`ifdef SAR_ADC_OVR_EN
  logic             ovr_pend_reg, ovr_pend_next;
  logic             ovr_reg, ovr_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      vhold_reg <= 0.0;
      trial_reg <= '0;
      idx_reg   <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef SAR_ADC_OVR_EN
      ovr_pend_reg <= 1'b0;
      ovr_reg      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      vhold_reg <= vhold_next;
      trial_reg <= trial_next;
      idx_reg   <= idx_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
`ifdef SAR_ADC_OVR_EN
      ovr_pend_reg <= ovr_pend_next;
      ovr_reg      <= ovr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    vhold_next = vhold_reg;
    trial_next = trial_reg;
    idx_next   = idx_reg;
    dout_next  = dout_reg;
    valid_next = 1'b0;
    busy_next  = busy_reg;
    trial_set  = trial_reg;
    threshold  = 0.0;
`ifdef SAR_ADC_OVR_EN
    ovr_pend_next = ovr_pend_reg;
    ovr_next      = ovr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CONV;
          vhold_next = bus.vin;
          trial_next = '0;
          idx_next   = IW'(NBITS - 1);
          busy_next  = 1'b1;
`ifdef SAR_ADC_OVR_EN
          ovr_pend_next = (bus.vin >= VREF_P) || (bus.vin < VREF_N);
`endif
        end
      end
      CONV: begin
        // Trial bit is still zero in trial_reg, so rejecting it means keeping trial_reg.
        trial_set[idx_reg] = 1'b1;
        threshold  = VREF_N + real'(trial_set) * LSB;
        trial_next = (vhold_reg >= threshold) ? trial_set : trial_reg;
        if (idx_reg == '0) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          valid_next = 1'b1;
          dout_next  = trial_next;
`ifdef SAR_ADC_OVR_EN
          ovr_next   = ovr_pend_reg;
`endif
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy  = busy_reg;
  assign bus.dout  = dout_reg;
  assign bus.valid = valid_reg;
`ifdef SAR_ADC_OVR_EN
  assign bus.ovr   = ovr_reg;
`endif
endmodule

// File: tb/tb_sar_adc_sampler.sv
// Self-checking bench for sar_adc_sampler (NBITS=6, VREF +/-0.5): vector table, random vs. ideal-quantiser model,
// and hand-written sequences for held start, ignored starts and mid-conversion reset.
module tb_sar_adc_sampler;
  localparam int  NB     = 6;
  localparam real VREF_P = 0.5;
  localparam real VREF_N = -0.5;
  localparam real LSB    = 1.0 / 64.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  sar_adc_sampler_if #(.NBITS(NB)) bus_if ();
  sar_adc_sampler #(.NBITS(NB), .VREF_P(VREF_P), .VREF_N(VREF_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    real vin;
    real vafter;
    int  exp_code;
    int  exp_ovr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Ideal quantiser: floor of the normalised input, saturated to the code range.
  function automatic int model_code(input real v);
    real x;
    x = (v - VREF_N) / LSB;
    if (x < 0.0) return 0;
    if (x >= 64.0) return 63;
    return int'($floor(x));
  endfunction

  function automatic int model_ovr(input real v);
    return ((v >= VREF_P) || (v < VREF_N)) ? 1 : 0;
  endfunction

  function automatic int cur_ovr();
`ifdef SAR_ADC_OVR_EN
    return int'(bus_if.ovr);
`else
    return 0;
`endif
  endfunction

  task automatic convert(input real v, input real v_after,
                         output int code, output int lat, output int bcnt, output int ovr_o);
    @(negedge clk);
    bus_if.vin   = v;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.vin   = v_after;
    lat  = 0;
    bcnt = 0;
    while (bus_if.valid !== 1'b1 && lat < 40) begin
      if (bus_if.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    code  = int'(bus_if.dout);
    ovr_o = cur_ovr();
  endtask

  task automatic run_one(input string tag, input real v, input real v_after,
                         input int exp_code, input int exp_ovr);
    int code, lat, bcnt, ovr_o;
    convert(v, v_after, code, lat, bcnt, ovr_o);
    $display("%s: vin=%f code=%0d lat=%0d busy_cycles=%0d", tag, v, code, lat, bcnt);
    check({tag, " latency"}, lat, 6);
    check({tag, " busy_cycles"}, bcnt, 6);
    check({tag, " dout"}, code, exp_code);
`ifdef SAR_ADC_OVR_EN
    check({tag, " ovr"}, ovr_o, exp_ovr);
`else
    if (exp_ovr < 0) check({tag, " ovr"}, ovr_o, exp_ovr);
`endif
    @(negedge clk);
    check({tag, " valid_one_cycle"}, bus_if.valid, 0);
    check({tag, " dout_held"}, bus_if.dout, exp_code);
  endtask

  initial begin
    int   code, lat, bcnt, ovr_o, nvalid, prev, k;
    real  v;
    real  ramp[31];

    vecs[0] = '{0.0,      0.0,  32, 0};
    vecs[1] = '{0.1,     -0.4,  38, 0};
    vecs[2] = '{-0.1875,  0.3,  20, 0};
    vecs[3] = '{0.49,     0.0,  63, 0};
    vecs[4] = '{-0.5,     0.2,   0, 0};
    vecs[5] = '{0.6,      0.0,  63, 1};
    vecs[6] = '{0.0,      0.6,  32, 0};
    vecs[7] = '{-0.6,     0.0,   0, 1};
    vecs[8] = '{0.5,     -0.5,  63, 1};
    vecs[9] = '{0.484375, 0.0,  63, 0};

    bus_if.vin   = 0.0;
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", bus_if.busy, 0);
    check("reset valid", bus_if.valid, 0);
    check("reset dout", bus_if.dout, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_one($sformatf("vec%0d", i), vecs[i].vin, vecs[i].vafter, vecs[i].exp_code, vecs[i].exp_ovr);

    // Random dyadic inputs slightly wider than the range, so saturation is exercised too.
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(1228, 0)) - 614;
      v = real'(k) / 1024.0;
      run_one($sformatf("rand%0d", i), v, real'(int'($urandom_range(1000, 0)) - 500) / 1000.0,
              model_code(v), model_ovr(v));
    end

    // start held high: samples every 7 cycles, each on the value driven just before its sampling edge.
    for (int n = 0; n <= 30; n++) ramp[n] = -0.5 + real'(n) * 0.03125 + 0.0078125;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.vin   = ramp[0];
    nvalid = 0;
    prev   = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus_if.valid === 1'b1) begin
        nvalid++;
        $display("held: valid at cycle %0d code=%0d", c, bus_if.dout);
        check("held spacing", c - prev, 7);
        check("held dout", bus_if.dout, model_code(ramp[c - 7]));
        prev = c;
      end
      bus_if.vin = ramp[c];
    end
    bus_if.start = 1'b0;
    check("held valid_count", nvalid, 4);
    k = 0;
    while (bus_if.busy === 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("held drain", bus_if.busy, 0);

    // Extra start pulses while busy are dropped, not queued.
    @(negedge clk);
    bus_if.vin = 0.25;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.vin = -0.25;
    nvalid = 0;
    code = -1;
    for (int c = 1; c <= 20; c++) begin
      bus_if.start = (c == 2 || c == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus_if.valid === 1'b1) begin nvalid++; code = int'(bus_if.dout); end
    end
    bus_if.start = 1'b0;
    $display("busy_start: valids=%0d code=%0d", nvalid, code);
    check("busy_start valid_count", nvalid, 1);
    check("busy_start dout", code, 48);

    // Reset during the third conversion cycle aborts without a valid.
    run_one("pre_reset", 0.49, 0.0, 63, 0);
    @(negedge clk);
    bus_if.vin = 0.3;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    $display("mid_reset: busy=%0b valid=%0b dout=%0d", bus_if.busy, bus_if.valid, bus_if.dout);
    check("mid_reset busy", bus_if.busy, 0);
    check("mid_reset valid", bus_if.valid, 0);
    check("mid_reset dout", bus_if.dout, 0);
    nvalid = 0;
    repeat (2) begin @(negedge clk); if (bus_if.valid === 1'b1) nvalid++; end
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (bus_if.valid === 1'b1) nvalid++; end
    check("mid_reset no_valid", nvalid, 0);
    run_one("post_reset", 0.0, 0.0, 32, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
